// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: loads always win, ALU results queue in a
// 2-entry FIFO and drain in acceptance order. Load data is extracted/extended here.
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [4:0]  rd,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic [31:0] pending,
  output logic        load_fault
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t     fifo_q [2];
  logic        head_q, tail_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d, fault_q, fault_d;

  logic        alu_acc, ld_acc, pop, byp, push;
  logic        ld_ok;
  logic [31:0] ld_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] pend;

  assign alu_ready = !reset && (cnt_q != 2'd2);
  assign ld_ready  = !reset;
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_acc    = ld_valid && ld_ready;

  // Any accepted load owns the write slot, even a faulting or x0 one.
  assign pop  = !ld_acc && (cnt_q != 2'd0);
  assign byp  = !ld_acc && (cnt_q == 2'd0) && alu_acc && (alu_rd != 5'd0);
  assign push = alu_acc && (alu_rd != 5'd0) && !byp;

  assign ld_byte = 8'(ld_word >> {ld_addr_lo, 3'b000});
  assign ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_ok  = 1'b1;
    ld_val = 32'd0;
    case (ld_funct3)
      3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_val = {24'd0, ld_byte};
      3'b001: begin ld_ok = !ld_addr_lo[0]; ld_val = {{16{ld_half[15]}}, ld_half}; end
      3'b101: begin ld_ok = !ld_addr_lo[0]; ld_val = {16'd0, ld_half}; end
      3'b010: begin ld_ok = (ld_addr_lo == 2'd0); ld_val = ld_word; end
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    rd_d    = 5'd0;
    data_d  = 32'd0;
    fault_d = 1'b0;
    if (ld_acc) begin
      if (!ld_ok) begin
        fault_d = 1'b1;
      end else if (ld_rd != 5'd0) begin
        we_d   = 1'b1;
        rd_d   = ld_rd;
        data_d = ld_val;
      end
    end else if (pop) begin
      we_d   = 1'b1;
      rd_d   = fifo_q[head_q].rd;
      data_d = fifo_q[head_q].data;
    end else if (byp) begin
      we_d   = 1'b1;
      rd_d   = alu_rd;
      data_d = alu_data;
    end
  end

  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      rd_q    <= 5'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      if (pop)  head_q <= ~head_q;
      if (push) tail_q <= ~tail_q;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= '{rd: alu_rd, data: alu_data};
  end

  always_comb begin
    pend = 32'd0;
    if (cnt_q != 2'd0) pend[fifo_q[head_q].rd]  = 1'b1;
    if (cnt_q == 2'd2) pend[fifo_q[~head_q].rd] = 1'b1;
    if (we_q)          pend[rd_q]               = 1'b1;
    pend[0] = 1'b0;
  end

  // Outputs are forced quiet for the whole reset cycle, not just after it.
  assign write_enable = we_q && !reset;
  assign rd           = reset ? 5'd0  : rd_q;
  assign write_data   = reset ? 32'd0 : data_q;
  assign load_fault   = fault_q && !reset;
  assign pending      = reset ? 32'd0 : pend;

endmodule

// File: tb/tb_writeback_unit.sv
// Writeback unit bench: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the arbitration rules.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_word;
  logic [4:0]  rd;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic        load_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .ld_word(ld_word),
    .rd(rd), .write_enable(write_enable), .write_data(write_data),
    .pending(pending), .load_fault(load_fault)
  );

  typedef struct {
    int unsigned rd;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Load semantics from the ISA: shift the word down, mask, optionally sign-extend.
  function automatic bit ld_model(input logic [2:0] f3, input logic [1:0] a,
                                  input logic [31:0] w, output logic [31:0] v);
    int unsigned b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
    v = 32'd0;
    case (f3)
      3'd0: begin v = (b >= 128) ? b - 256 : b; return 1; end
      3'd4: begin v = b; return 1; end
      3'd1: begin if (a % 2 != 0) return 0; v = (h >= 32768) ? h - 65536 : h; return 1; end
      3'd5: begin if (a % 2 != 0) return 0; v = h; return 1; end
      3'd2: begin if (a != 0) return 0; v = w; return 1; end
      default: return 0;
    endcase
  endfunction

  // One clock cycle: drive, check readies, step the model, check registered outputs.
  task automatic cyc(input logic rst, input logic lv, input logic [4:0] lrd,
                     input logic [2:0] f3, input logic [1:0] la, input logic [31:0] lw,
                     input logic av, input logic [4:0] ard, input logic [31:0] ad);
    bit aacc, lacc, ok;
    logic [31:0] lval, epend, edata;
    logic [4:0]  erd;
    logic        ewe, efault;
    ent_t        e;
    reset = rst; ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_addr_lo = la;
    ld_word = lw; alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    chk("alu_ready", {31'd0, alu_ready}, (!rst && q.size() < 2) ? 32'd1 : 32'd0);
    chk("ld_ready", {31'd0, ld_ready}, rst ? 32'd0 : 32'd1);
    aacc = av && !rst && q.size() < 2;
    lacc = lv && !rst;
    ewe = 0; erd = 0; edata = 0; efault = 0;
    if (rst) begin
      q.delete();
    end else begin
      if (lacc) begin
        ok = ld_model(f3, la, lw, lval);
        if (!ok) efault = 1;
        else if (lrd != 0) begin ewe = 1; erd = lrd; edata = lval; end
      end else if (q.size() > 0) begin
        e = q.pop_front();
        ewe = 1; erd = 5'(e.rd); edata = e.d;
      end else if (aacc && ard != 0) begin
        ewe = 1; erd = ard; edata = ad; aacc = 0;
      end
      if (aacc && ard != 0) q.push_back('{rd: ard, d: ad});
    end
    @(posedge clk); #1;
    epend = 0;
    foreach (q[i]) epend = epend | (32'd1 << q[i].rd);
    if (ewe) epend = epend | (32'd1 << erd);
    epend[0] = 1'b0;
    chk("write_enable", {31'd0, write_enable}, {31'd0, ewe});
    chk("rd", {27'd0, rd}, {27'd0, erd});
    chk("write_data", write_data, edata);
    chk("load_fault", {31'd0, load_fault}, {31'd0, efault});
    chk("pending", pending, epend);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; alu_valid = 0; alu_rd = 0; alu_data = 0; ld_valid = 0;
    ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_word = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 3'd2, 0, 32'hDEAD_BEEF, 1, 9, 32'h1);
    idle(1);

    // ALU only, then collision
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 32'h7);
    idle(1);
    cyc(0, 1, 3, 3'd2, 0, 32'h1234_5678, 1, 4, 32'hFFFF_FFFF);
    idle(2);

    // Backpressure: loads every cycle, ALU holds its third result until taken
    cyc(0, 1, 1, 3'd2, 0, 32'h11, 1, 10, 32'hA0);
    cyc(0, 1, 2, 3'd2, 0, 32'h22, 1, 11, 32'hA1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 6, 3'd2, 0, 32'h33 + i, 1, 12, 32'hA2);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 12, 32'hA2);
    idle(3);

    // Extension cases
    cyc(0, 1, 7, 3'd0, 2, 32'h0080_0000, 0, 0, 0);
    cyc(0, 1, 7, 3'd4, 2, 32'h0080_0000, 0, 0, 0);
    cyc(0, 1, 7, 3'd1, 2, 32'h8001_0000, 0, 0, 0);
    cyc(0, 1, 7, 3'd5, 2, 32'h8001_0000, 0, 0, 0);
    cyc(0, 1, 7, 3'd0, 1, 32'h0000_F000, 0, 0, 0);

    // Faults with a FIFO head waiting, and x0 targets
    cyc(0, 1, 8, 3'd2, 0, 32'h5, 1, 13, 32'hB0);
    cyc(0, 1, 8, 3'd1, 1, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(0, 1, 8, 3'd2, 2, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(0, 1, 8, 3'd3, 0, 32'hFFFF_FFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'h99);
    cyc(0, 1, 0, 3'd2, 0, 32'h77, 0, 0, 0);
    idle(2);

    // Reset mid-flight with a full FIFO
    cyc(0, 1, 1, 3'd2, 0, 32'h1, 1, 14, 32'hC0);
    cyc(0, 1, 2, 3'd2, 0, 32'h2, 1, 15, 32'hC1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] w;
      w = $urandom;
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), 3'($urandom),
          2'($urandom), w,
          ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-002 The ALU result port SHALL be:
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1.
- alu_rd  in  5  destination register.
- alu_data  in  32  signed result.
REQ-003 The load result port SHALL be:
- ld_valid  in  1  load data offered.
- ld_ready  out  1  load accepted this cycle when ld_valid=1.
- ld_rd  in  5  destination register.
- ld_funct3  in  3  load type.
- ld_addr_lo  in  2  byte address bits [1:0].
- ld_word  in  32  raw aligned memory word.
REQ-004 The register-file write port SHALL be:
- rd  out  5  write destination.
- write_enable  out  1  write strobe.
- write_data  out  32  signed write value.
REQ-005 Status outputs SHALL be:
- pending  out  32  one-hot OR of destination registers not yet written.
- load_fault  out  1  one-cycle pulse on an illegal or misaligned load.

Function
REQ-006 rd, write_enable and write_data SHALL be registered, with at most one write per cycle; the write appears in the cycle after the source entry is selected.
REQ-007 A handshake SHALL complete when valid and ready are both 1 in the same cycle; inputs are sampled only then.
REQ-008 ld_ready SHALL be 1 in every cycle except while reset is asserted; loads are never stalled.
REQ-009 A 2-entry ALU FIFO SHALL buffer ALU results; alu_ready SHALL equal (FIFO count < 2) and SHALL be 0 during reset.
REQ-010 Output selection each cycle SHALL follow this priority:
- accepted load;
- else FIFO head;
- else ALU result accepted this cycle (bypass, not enqueued);
- else write_enable=0.
REQ-011 An ALU result accepted in a cycle where it is not selected SHALL be enqueued. A pop and a push in the same cycle SHALL leave the count unchanged and preserve order.
REQ-012 ALU results SHALL be written in acceptance order.
REQ-013 Any accepted entry with rd=0 SHALL complete its handshake, SHALL NOT be enqueued, and SHALL NOT produce write_enable=1.
REQ-014 Load data SHALL be extracted from ld_word as follows:
- funct3=000 (lb): byte ld_word[8*addr_lo+:8], sign-extended.
- funct3=100 (lbu): same byte, zero-extended.
- funct3=001 (lh): halfword at ld_word[16*addr_lo[1]+:16], sign-extended.
- funct3=101 (lhu): same halfword, zero-extended.
- funct3=010 (lw): full word.
REQ-015 A load with any other funct3, lh/lhu with addr_lo[0]=1, or lw with addr_lo!=0 SHALL produce no write and SHALL pulse load_fault=1 in the following cycle. The FIFO head still waits that cycle.
REQ-016 pending SHALL be the OR of:
- one-hot(rd) of each valid FIFO entry;
- one-hot(rd) of the current output when write_enable=1.
pending[0] SHALL always be 0.
REQ-017 When write_enable=0 and no writes are in flight, write_data and rd SHALL be 0.

Reset
REQ-018 While reset=1, the block SHALL hold: FIFO empty; rd=0; write_enable=0; write_data=0; pending=0; load_fault=0; alu_ready=0; ld_ready=0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries with no further writes. alu_ready and ld_ready SHALL return to 1 in the first cycle after reset deasserts.

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- ALU only: alu_rd=5, data=0x0000_0007 accepted in cycle N -> rd=5, write_enable=1, write_data=7 in cycle N+1; pending[5]=1 in N+1 only.
- Collision: load (rd=3, lw, word 0x1234_5678) and ALU (rd=4, 0xFFFF_FFFF) accepted in cycle N -> N+1 writes x3=0x1234_5678; N+2 writes x4=0xFFFF_FFFF; pending=0x18 in N+1.
- Backpressure: loads every cycle while the ALU offers 3 results -> alu_ready drops to 0 after 2 enqueued; the third is accepted only after a pop; write order matches acceptance.
- Extension: lb with addr_lo=2 and word 0x0080_0000 -> 0xFFFF_FF80; lbu same -> 0x0000_0080; lh addr_lo=2 with word 0x8001_0000 -> 0xFFFF_8001.
- Fault and x0: lh with addr_lo=1 -> load_fault=1 for one cycle, no write. ALU with rd=0 -> handshake completes, write_enable stays 0.
- Reset mid-flight: FIFO holding 2 entries and reset pulsed for 1 cycle -> no further writes, pending=0, alu_ready=1 in the cycle after reset deasserts.
